// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction fetch front end. Generates sequential word-aligned fetch
// addresses, tracks requests that have been accepted by instruction memory
// but not yet answered, and buffers returned instructions (with their PCs)
// in a small in-order prefetch queue for the decode stage.
//
// A jump redirects fetch to a new target. It flushes the queue and arranges
// for every response still owed by memory for the old path to be discarded.
//
// Parameters
//   XLEN        width of PCs and addresses
//   DEPTH       prefetch queue entries (power of two, at least 2)
//   RESET_ADDR  fetch address after reset (word aligned)
//
// Ports
//   clk, reset                 clock and asynchronous active-high reset
//   enable                     permits new fetch requests
//   jump, pc_imm               redirect request and its target
//   imem_req_valid/ready/addr  request channel to instruction memory
//   imem_rsp_valid/data        in-order response channel (no back-pressure)
//   instr_valid/ready          queue head handshake towards the consumer
//   instr, instr_pc            queue head instruction and its PC
//   pc_current                 address of the next request to issue
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            jump,
    input  logic [XLEN-1:0] pc_imm,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_current
);

    localparam int              PTR_W     = $clog2(DEPTH);
    localparam int              CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]  OCC_LIMIT = (CNT_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   resp_pc;
    logic [XLEN-1:0]   jump_target;

    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic [31:0]       q_data [DEPTH];
    logic [XLEN-1:0]   q_pc   [DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              credit_ok;
    logic              req_fire;
    logic              rsp_take;
    logic              rsp_push;
    logic              pop;

    // Every outstanding request reserves a queue slot, so a response can
    // always be pushed and no overflow handling is needed.
    assign occupancy   = {1'b0, inflight} + {1'b0, count};
    assign credit_ok   = occupancy < OCC_LIMIT;

    // Masking keeps the low bits of the target in the expression while
    // forcing word alignment.
    assign jump_target = pc_imm & ~(XLEN'(3));

    assign req_fire    = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding cannot belong to any request of
    // ours and is ignored entirely.
    assign rsp_take    = imem_rsp_valid && (inflight != '0);

    // Responses owed to the pre-jump path, and any arriving in the jump
    // cycle itself, are consumed without being queued.
    assign rsp_push    = rsp_take && !jump && (drop_cnt == '0);

    assign pop         = instr_valid && instr_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: enable alone moves between idle and fetching; jump
    // never changes the state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = FETCH;
            FETCH:   if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: requests are suppressed during a jump so the old
    // fetch_pc is never sent once a redirect is known.
    always_comb begin
        imem_req_valid = 1'b0;
        if ((state == FETCH) && !jump && credit_ok) begin
            imem_req_valid = 1'b1;
        end
    end

    // Fetch/response PCs, outstanding-request bookkeeping and queue
    // pointers. A jump resets the queue and converts everything still
    // outstanding (minus a response arriving right now) into drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_ADDR;
            resp_pc  <= RESET_ADDR;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (jump) begin
            fetch_pc <= jump_target;
            resp_pc  <= jump_target;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            drop_cnt <= inflight - CNT_W'(rsp_take);
            inflight <= inflight - CNT_W'(rsp_take);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end

            if (rsp_push) begin
                resp_pc <= resp_pc + XLEN'(4);
                tail    <= tail + PTR_W'(1);
            end

            if (pop) begin
                head <= head + PTR_W'(1);
            end

            if (rsp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end

            case ({req_fire, rsp_take})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase

            case ({rsp_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only visible while count
    // says they are valid.
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            q_data[tail] <= imem_rsp_data;
            q_pc[tail]   <= resp_pc;
        end
    end

    // Head outputs read as zero whenever the queue is empty, which also
    // gives the required zero values during reset.
    always_comb begin
        instr_valid = (count != '0);
        instr       = '0;
        instr_pc    = '0;
        if (instr_valid) begin
            instr    = q_data[head];
            instr_pc = q_pc[head];
        end
    end

    assign imem_req_addr = fetch_pc;
    assign pc_current    = fetch_pc;

endmodule
